// File: rtl/skolem_pkg.sv
// Shared types and helpers for the Skolem XOR-specification verifier.
// Holds the sweep FSM encoding, the XOR spec predicate and the latency ceiling.
package skolem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int MAX_LAT = 7;

  // Operands are zero-extended to 16 bits; padding does not change the parity.
  function automatic logic xor_spec(input logic [15:0] x, input logic [15:0] y,
                                    input logic parity);
    return ((^x) ^ (^y)) == parity;
  endfunction

endpackage

// File: rtl/skolem_lat_pipe.sv
// Valid + data delay line matching the candidate's pipeline latency.
// DEPTH=0 is a pure wire; otherwise DEPTH register stages with async clear and sync flush.
module skolem_lat_pipe #(
  parameter int DEPTH = 0,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  output logic         empty
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = clk ^ rst_n ^ flush;
      assign out_vld     = in_vld;
      assign out_dat     = in_dat;
      assign empty       = 1'b1;
    end else begin : g_pipe
      logic [DEPTH-1:0] vld_q, vld_d;
      logic [W-1:0]     dat_q [DEPTH];
      logic [W-1:0]     dat_d [DEPTH];

      always_comb begin
        vld_d = '0;
        for (int i = 0; i < DEPTH; i++) dat_d[i] = '0;
        if (!flush) begin
          vld_d[0] = in_vld;
          dat_d[0] = in_dat;
          for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else begin
          vld_q <= vld_d;
          for (int i = 0; i < DEPTH; i++) dat_q[i] <= dat_d[i];
        end
      end

      assign out_vld = vld_q[DEPTH-1];
      assign out_dat = dat_q[DEPTH-1];
      assign empty   = ~|vld_q;
    end
  endgenerate

endmodule

// File: rtl/skolem_xor_verifier.sv
// Exhaustive in-circuit checker of a Skolem candidate against F(X,Y) = (^X ^ ^Y) == PARITY.
// Optional macro SKOLEM_VERIFY_CEX_COUNT_EN: full sweep with a fail_cnt output counting all violations.
module skolem_xor_verifier
  import skolem_pkg::*;
#(
  parameter int   N_IN     = 4,
  parameter int   N_OUT    = 3,
  parameter logic PARITY   = 1'b1,
  parameter int   CAND_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  cand_x,
  output logic             cand_vld,
  input  logic [N_OUT-1:0] cand_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN-1:0]  cex_x,
  output logic [N_OUT-1:0] cex_y,
`ifdef SKOLEM_VERIFY_CEX_COUNT_EN
  output logic [N_IN:0]    fail_cnt,
`endif
  output logic [N_IN:0]    n_checked
);

  localparam int LAT = (CAND_LAT > MAX_LAT) ? MAX_LAT : CAND_LAT;
  localparam logic [N_IN:0] LAST_X = {1'b0, {N_IN{1'b1}}};
`ifdef SKOLEM_VERIFY_CEX_COUNT_EN
  localparam bit STOP_AT_FIRST = 1'b0;
`else
  localparam bit STOP_AT_FIRST = 1'b1;
`endif

  state_e           state_q, state_d;
  logic [N_IN:0]    cnt_q, cnt_d;
  logic [N_IN:0]    n_checked_q, n_checked_d;
  logic             fail_q, fail_d;
  logic [N_IN-1:0]  cex_x_q, cex_x_d;
  logic [N_OUT-1:0] cex_y_q, cex_y_d;
`ifdef SKOLEM_VERIFY_CEX_COUNT_EN
  logic [N_IN:0]    fail_cnt_q, fail_cnt_d;
`endif

  logic            issue_vld;
  logic [N_IN-1:0] issue_x;
  logic            chk_vld;
  logic [N_IN-1:0] chk_x;
  logic            pipe_empty;
  logic            busy_w;
  logic            chk_en;
  logic            chk_ok;

  assign busy_w    = (state_q == SWEEP) || (state_q == DRAIN);
  assign issue_vld = (state_q == SWEEP);
  assign issue_x   = issue_vld ? cnt_q[N_IN-1:0] : '0;

  // Aligns each issued assignment with the candidate's answer for it.
  skolem_lat_pipe #(
    .DEPTH (LAT),
    .W     (N_IN)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (abort),
    .in_vld  (issue_vld),
    .in_dat  (issue_x),
    .out_vld (chk_vld),
    .out_dat (chk_x),
    .empty   (pipe_empty)
  );

  assign chk_ok = xor_spec(16'(chk_x), 16'(cand_y), PARITY);
  // After a stop-at-first failure, answers still in flight are ignored.
  assign chk_en = chk_vld && busy_w && !(STOP_AT_FIRST && fail_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_checked_d = n_checked_q;
    fail_d      = fail_q;
    cex_x_d     = cex_x_q;
    cex_y_d     = cex_y_q;
`ifdef SKOLEM_VERIFY_CEX_COUNT_EN
    fail_cnt_d  = fail_cnt_q;
`endif

    if (chk_en) begin
      n_checked_d = n_checked_q + 1'b1;
      if (!chk_ok) begin
        if (!fail_q) begin
          fail_d  = 1'b1;
          cex_x_d = chk_x;
          cex_y_d = cand_y;
        end
`ifdef SKOLEM_VERIFY_CEX_COUNT_EN
        fail_cnt_d = fail_cnt_q + 1'b1;
`endif
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SWEEP;
          cnt_d       = '0;
          n_checked_d = '0;
          fail_d      = 1'b0;
          cex_x_d     = '0;
          cex_y_d     = '0;
`ifdef SKOLEM_VERIFY_CEX_COUNT_EN
          fail_cnt_d  = '0;
`endif
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_X) state_d = DRAIN;
        if (STOP_AT_FIRST && chk_en && !chk_ok) state_d = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d     = IDLE;
      cnt_d       = '0;
      n_checked_d = '0;
      fail_d      = 1'b0;
      cex_x_d     = '0;
      cex_y_d     = '0;
`ifdef SKOLEM_VERIFY_CEX_COUNT_EN
      fail_cnt_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_checked_q <= '0;
      fail_q      <= 1'b0;
      cex_x_q     <= '0;
      cex_y_q     <= '0;
`ifdef SKOLEM_VERIFY_CEX_COUNT_EN
      fail_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_checked_q <= n_checked_d;
      fail_q      <= fail_d;
      cex_x_q     <= cex_x_d;
      cex_y_q     <= cex_y_d;
`ifdef SKOLEM_VERIFY_CEX_COUNT_EN
      fail_cnt_q  <= fail_cnt_d;
`endif
    end
  end

  assign cand_x    = issue_x;
  assign cand_vld  = issue_vld;
  assign busy      = busy_w;
  assign done      = (state_q == DONE);
  assign pass      = (state_q == DONE) && !fail_q;
  assign cex_x     = cex_x_q;
  assign cex_y     = cex_y_q;
  assign n_checked = n_checked_q;
`ifdef SKOLEM_VERIFY_CEX_COUNT_EN
  assign fail_cnt  = fail_cnt_q;
`endif

endmodule

// File: tb/tb_skolem_xor_verifier.sv
// Scoreboard bench: two verifiers (candidate latency 0 and 3) share one candidate truth table.
// Expected results come from an exhaustive parity model over the table.
module tb_skolem_xor_verifier;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N_OUT-1:0] y_tab [16];

  logic [N_IN-1:0]  cx0, cx3, cex_x0, cex_x3;
  logic [N_OUT-1:0] cy0, cy3, cex_y0, cex_y3;
  logic             cv0, cv3, busy0, busy3, done0, done3, pass0, pass3;
  logic [N_IN:0]    nc0, nc3, fc0, fc3;
  logic [N_OUT-1:0] s1, s2, s3;

  // Candidate models: combinational for DUT0, three-register pipeline for DUT3.
  assign cy0 = y_tab[cx0];
  always @(posedge clk) begin
    s1 <= y_tab[cx3];
    s2 <= s1;
    s3 <= s2;
  end
  assign cy3 = s3;

  skolem_xor_verifier #(.N_IN(N_IN), .N_OUT(N_OUT), .PARITY(1'b1), .CAND_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cand_x(cx0), .cand_vld(cv0), .cand_y(cy0), .busy(busy0), .done(done0), .pass(pass0),
    .cex_x(cex_x0), .cex_y(cex_y0),
`ifdef SKOLEM_VERIFY_CEX_COUNT_EN
    .fail_cnt(fc0),
`endif
    .n_checked(nc0)
  );

  skolem_xor_verifier #(.N_IN(N_IN), .N_OUT(N_OUT), .PARITY(1'b1), .CAND_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cand_x(cx3), .cand_vld(cv3), .cand_y(cy3), .busy(busy3), .done(done3), .pass(pass3),
    .cex_x(cex_x3), .cex_y(cex_y3),
`ifdef SKOLEM_VERIFY_CEX_COUNT_EN
    .fail_cnt(fc3),
`endif
    .n_checked(nc3)
  );

`ifndef SKOLEM_VERIFY_CEX_COUNT_EN
  assign fc0 = '0;
  assign fc3 = '0;
`endif

  typedef struct {
    int         start_cyc;
    int         lat;
    logic       pass;
    logic [3:0] cx;
    logic [2:0] cy;
    int         nchk;
    int         fcnt;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: evaluate the spec on every assignment, then derive the reported result.
  function automatic exp_t model(input int lat);
    exp_t e;
    int   first;
    first  = -1;
    e.fcnt = 0;
    e.start_cyc = 0;
    for (int x = 0; x < 16; x++) begin
      if ((($countones(4'(x)) + $countones(y_tab[x])) % 2) != 1) begin
        e.fcnt++;
        if (first < 0) first = x;
      end
    end
    e.pass = (first < 0);
    e.cx   = (first < 0) ? 4'd0 : 4'(first);
    e.cy   = (first < 0) ? 3'd0 : y_tab[first];
`ifdef SKOLEM_VERIFY_CEX_COUNT_EN
    e.nchk = 16;
    e.lat  = 16 + lat + 1;
`else
    e.nchk = (first < 0) ? 16 : first + 1;
    e.lat  = (first < 0) ? 16 + lat + 1 : -1;
`endif
    return e;
  endfunction

  task automatic score(input string tag, input exp_t e, input logic p, input logic [3:0] cx,
                       input logic [2:0] cy, input logic [4:0] nc, input logic [4:0] fc);
    if (e.lat >= 0) chk({tag, ".latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
    chk({tag, ".pass"}, 32'(p), 32'(e.pass));
    chk({tag, ".cex_x"}, 32'(cx), 32'(e.cx));
    chk({tag, ".cex_y"}, 32'(cy), 32'(e.cy));
    chk({tag, ".n_checked"}, 32'(nc), 32'(e.nchk));
`ifdef SKOLEM_VERIFY_CEX_COUNT_EN
    chk({tag, ".fail_cnt"}, 32'(fc), 32'(e.fcnt));
`else
    if (fc !== 5'd0) chk({tag, ".fail_cnt_tie"}, 32'(fc), 32'd0);
`endif
  endtask

  logic dprev0 = 1'b0;
  logic dprev3 = 1'b0;

  always @(negedge clk) begin
    if (rst_n && done0 && !dprev0) begin
      if (q0.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL dut0.unexpected_done: got done=1, expected no result pending");
      end else score("dut0", q0.pop_front(), pass0, cex_x0, cex_y0, nc0, fc0);
    end
    dprev0 <= done0;
  end

  always @(negedge clk) begin
    if (rst_n && done3 && !dprev3) begin
      if (q3.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL dut3.unexpected_done: got done=1, expected no result pending");
      end else score("dut3", q3.pop_front(), pass3, cex_x3, cex_y3, nc3, fc3);
    end
    dprev3 <= done3;
  end

  task automatic set_correct();
    for (int x = 0; x < 16; x++) y_tab[x] = ($countones(4'(x)) % 2 == 0) ? 3'd1 : 3'd0;
  endtask

  task automatic set_random();
    set_correct();
    for (int x = 0; x < 16; x++)
      if ($urandom_range(0, 5) == 0) y_tab[x] = 3'($urandom_range(0, 7));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".dut0_outs"}, 32'({cx0, cv0, busy0, done0, pass0, cex_x0, cex_y0, nc0}), 32'd0);
    chk({tag, ".dut3_outs"}, 32'({cx3, cv3, busy3, done3, pass3, cex_x3, cex_y3, nc3}), 32'd0);
  endtask

  task automatic do_sweep(input bit poke);
    exp_t e0, e3;
    e0 = model(0);
    e3 = model(3);
    @(negedge clk);
    start = 1'b1;
    e0.start_cyc = cyc + 1;
    e3.start_cyc = cyc + 1;
    q0.push_back(e0);
    q3.push_back(e3);
    @(negedge clk);
    start = 1'b0;
    chk("start.done_drop0", 32'(done0), 32'd0);
    chk("start.done_drop3", 32'(done3), 32'd0);
    chk("start.busy3", 32'(busy3), 32'd1);
    if (poke) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 100 && (q0.size() != 0 || q3.size() != 0); i++) @(negedge clk);
    if (q0.size() != 0 || q3.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL sweep_timeout: got %0d/%0d results pending, expected 0", q0.size(), q3.size());
      q0.delete();
      q3.delete();
    end
  endtask

  initial begin
    set_correct();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    set_correct();
    do_sweep(1'b0);
    set_correct();
    y_tab[10] = 3'b000;
    do_sweep(1'b0);
    for (int x = 0; x < 16; x++) y_tab[x] = 3'b000;
    do_sweep(1'b0);
    set_correct();
    do_sweep(1'b1);

    // Abort at sweep cycle 5, then a clean full run.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.state0", 32'({busy0, done0, cv0, pass0}), 32'd0);
    chk("abort.state3", 32'({busy3, done3, cv3, pass3}), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    do_sweep(1'b0);

    // Abort and start together from DONE: abort wins.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_vs_start0", 32'({busy0, done0, pass0}), 32'd0);
    chk("abort_vs_start3", 32'({busy3, done3, pass3}), 32'd0);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;

    // Reset asserted while the latency-3 verifier drains.
    set_correct();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    chk("drain.busy3", 32'({busy3, cv3, done3}), 32'b100);
    rst_n = 1'b0;
    #1;
    check_zero("drain_reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_sweep(1'b0);

    for (int r = 0; r < 8; r++) begin
      set_random();
      do_sweep(r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
